// File: rtl/spike_event_encoder.sv
// Spike edge -> timestamped event encoder: refractory filter, FWFT FIFO, valid/ready out.
// Optional macro SPIKE_DROP_CNT_EN adds a saturating drop_cnt output.
module spike_event_encoder #(
  parameter int TS_W    = 16,
  parameter int DEPTH   = 4,
  parameter int REFRACT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     spike_in,
  input  logic                     ovf_clr,
  input  logic                     event_ready,
  output logic                     event_valid,
  output logic [TS_W-1:0]          event_ts,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ovf
`ifdef SPIKE_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  logic [TS_W-1:0] ts_q, ts_d;
  logic            spike_prev_q;
  logic [RW-1:0]   refr_q, refr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [TS_W-1:0] head_q, head_d;
  logic [TS_W-1:0] mem_q [DEPTH];

  logic edge_det, accept, reject, pop, push, full, drop_full;

  assign edge_det  = spike_in & ~spike_prev_q;
  assign accept    = edge_det && (refr_q == '0);
  assign reject    = edge_det && (refr_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  assign pop       = event_valid & event_ready;
  assign push      = accept && (!full || pop);
  assign drop_full = accept && full && !pop;

  always_comb begin
    ts_d     = ts_q + TS_W'(1);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    refr_d = refr_q;
    if (accept)
      refr_d = RW'(REFRACT);
    else if (refr_q != '0)
      refr_d = refr_q - RW'(1);

    ovf_d = ovf_q;
    if (drop_full)
      ovf_d = 1'b1;
    else if (ovf_clr)
      ovf_d = 1'b0;

    // Head register tracks the entry that will be at rd_ptr next cycle,
    // bypassing the write when that slot is being filled right now.
    head_d = head_q;
    if (level_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d))
        head_d = ts_q;
      else
        head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= ts_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q         <= '0;
      spike_prev_q <= 1'b0;
      refr_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ovf_q        <= 1'b0;
      head_q       <= '0;
    end else begin
      ts_q         <= ts_d;
      spike_prev_q <= spike_in;
      refr_q       <= refr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ovf_q        <= ovf_d;
      head_q       <= head_d;
    end
  end

  assign event_valid = (level_q != '0);
  assign event_ts    = head_q;
  assign fifo_level  = level_q;
  assign ovf         = ovf_q;

`ifdef SPIKE_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  logic       lost;

  assign lost = reject | drop_full;

  // A loss in the clearing cycle still counts, so the count restarts at 1.
  always_comb begin
    drop_d = drop_q;
    if (ovf_clr)
      drop_d = lost ? 8'd1 : 8'd0;
    else if (lost && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_q <= '0;
    else
      drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule
